// File: rtl/opl3_write_arbiter.sv
// rtl/opl3_write_arbiter.sv - round-robin two-requester OPL3 register write master.
// Optional build macro OPL3_ARB_ADDR_CACHE_EN skips the address phase on a repeated {bank,addr}.
module opl3_write_arbiter #(
  parameter int PULSE_CYCLES = 2,
  parameter int ADDR_WAIT    = 4,
  parameter int DATA_WAIT    = 4
) (
  input  logic            clk,
  input  logic            ic_n,
  input  logic [1:0]      req_valid,
  output logic [1:0]      req_ready,
  input  logic [1:0]      req_bank,
  input  logic [1:0][7:0] req_addr,
  input  logic [1:0][7:0] req_data,
  output logic            cs_n,
  output logic            rd_n,
  output logic            wr_n,
  output logic [1:0]      address,
  output logic [7:0]      din,
  output logic            busy,
  output logic            last_grant
);

  localparam int MAX_AP  = (PULSE_CYCLES > ADDR_WAIT) ? PULSE_CYCLES : ADDR_WAIT;
  localparam int MAX_ALL = (MAX_AP > DATA_WAIT) ? MAX_AP : DATA_WAIT;
  localparam int CW      = (MAX_ALL < 1) ? 1 : $clog2(MAX_ALL + 1);
  localparam logic [CW-1:0] PULSE_LAST = CW'(PULSE_CYCLES - 1);
  localparam logic [CW-1:0] AW_LAST    = CW'((ADDR_WAIT > 0) ? ADDR_WAIT - 1 : 0);
  localparam logic [CW-1:0] DW_LAST    = CW'((DATA_WAIT > 0) ? DATA_WAIT - 1 : 0);

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR_PULSE, S_ADDR_WAIT, S_DATA_PULSE, S_DATA_WAIT
  } state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   cnt, cnt_nxt;
  logic            lat_bank;
  logic [7:0]      lat_addr, lat_data;
  logic            winner, take, hit;
  logic [1:0]      address_nxt;
  logic [7:0]      din_nxt;

  assign rd_n = 1'b1;

  // With both valid the requester not served last wins; otherwise the lone valid one.
  assign winner    = (req_valid == 2'b11) ? ~last_grant : req_valid[1];
  assign take      = (state == S_IDLE) && (|req_valid);
  assign req_ready = take ? (winner ? 2'b10 : 2'b01) : 2'b00;

`ifdef OPL3_ARB_ADDR_CACHE_EN
  logic       cache_valid;
  logic [8:0] cache_tag;

  assign hit = cache_valid && (cache_tag == {req_bank[winner], req_addr[winner]});

  always_ff @(posedge clk or negedge ic_n) begin
    if (!ic_n) begin
      cache_valid <= 1'b0;
      cache_tag   <= '0;
    end else if (state == S_ADDR_PULSE && cnt == PULSE_LAST) begin
      cache_valid <= 1'b1;
      cache_tag   <= {lat_bank, lat_addr};
    end
  end
`else
  assign hit = 1'b0;
`endif

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt + 1'b1;
    address_nxt = address;
    din_nxt     = din;
    case (state)
      S_IDLE: begin
        cnt_nxt = '0;
        if (take) begin
          if (hit) begin
            state_nxt   = S_DATA_PULSE;
            address_nxt = {req_bank[winner], 1'b1};
            din_nxt     = req_data[winner];
          end else begin
            state_nxt   = S_ADDR_PULSE;
            address_nxt = {req_bank[winner], 1'b0};
            din_nxt     = req_addr[winner];
          end
        end
      end
      S_ADDR_PULSE: begin
        if (cnt == PULSE_LAST) begin
          cnt_nxt = '0;
          if (ADDR_WAIT > 0) begin
            state_nxt = S_ADDR_WAIT;
          end else begin
            state_nxt   = S_DATA_PULSE;
            address_nxt = {lat_bank, 1'b1};
            din_nxt     = lat_data;
          end
        end
      end
      S_ADDR_WAIT: begin
        if (cnt == AW_LAST) begin
          cnt_nxt     = '0;
          state_nxt   = S_DATA_PULSE;
          address_nxt = {lat_bank, 1'b1};
          din_nxt     = lat_data;
        end
      end
      S_DATA_PULSE: begin
        if (cnt == PULSE_LAST) begin
          cnt_nxt   = '0;
          state_nxt = (DATA_WAIT > 0) ? S_DATA_WAIT : S_IDLE;
        end
      end
      S_DATA_WAIT: begin
        if (cnt == DW_LAST) begin
          cnt_nxt   = '0;
          state_nxt = S_IDLE;
        end
      end
      default: begin
        cnt_nxt   = '0;
        state_nxt = S_IDLE;
      end
    endcase
  end

  // Strobes are decoded from the next state so they change only on clock edges.
  always_ff @(posedge clk or negedge ic_n) begin
    if (!ic_n) begin
      state      <= S_IDLE;
      cnt        <= '0;
      cs_n       <= 1'b1;
      wr_n       <= 1'b1;
      address    <= 2'b00;
      din        <= 8'h00;
      busy       <= 1'b0;
      last_grant <= 1'b1;
      lat_bank   <= 1'b0;
      lat_addr   <= 8'h00;
      lat_data   <= 8'h00;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      cs_n    <= !(state_nxt == S_ADDR_PULSE || state_nxt == S_DATA_PULSE);
      wr_n    <= !(state_nxt == S_ADDR_PULSE || state_nxt == S_DATA_PULSE);
      busy    <= (state_nxt != S_IDLE);
      address <= address_nxt;
      din     <= din_nxt;
      if (take) begin
        last_grant <= winner;
        lat_bank   <= req_bank[winner];
        lat_addr   <= req_addr[winner];
        lat_data   <= req_data[winner];
      end
    end
  end

endmodule

// File: tb/tb_opl3_write_arbiter.sv
// tb/tb_opl3_write_arbiter.sv - scoreboard bench for opl3_write_arbiter.
module tb_opl3_write_arbiter;

`ifdef OPL3_ARB_ADDR_CACHE_EN
  localparam bit CACHE = 1'b1;
`else
  localparam bit CACHE = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic            ic_n;
  logic [1:0]      req_valid, req_ready, req_bank;
  logic [1:0][7:0] req_addr, req_data;
  logic            cs_n, rd_n, wr_n, busy, last_grant;
  logic [1:0]      address;
  logic [7:0]      din;

  logic [1:0]      f_valid, f_ready, f_bank;
  logic [1:0][7:0] f_addr, f_data;
  logic            f_cs_n, f_rd_n, f_wr_n, f_busy, f_last;
  logic [1:0]      f_address;
  logic [7:0]      f_din;

  opl3_write_arbiter dut (
    .clk(clk), .ic_n(ic_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_bank(req_bank), .req_addr(req_addr), .req_data(req_data),
    .cs_n(cs_n), .rd_n(rd_n), .wr_n(wr_n), .address(address), .din(din),
    .busy(busy), .last_grant(last_grant)
  );

  opl3_write_arbiter #(.PULSE_CYCLES(1), .ADDR_WAIT(0), .DATA_WAIT(0)) u_fast (
    .clk(clk), .ic_n(ic_n), .req_valid(f_valid), .req_ready(f_ready),
    .req_bank(f_bank), .req_addr(f_addr), .req_data(f_data),
    .cs_n(f_cs_n), .rd_n(f_rd_n), .wr_n(f_wr_n), .address(f_address), .din(f_din),
    .busy(f_busy), .last_grant(f_last)
  );

  int tests = 0;
  int fails = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  typedef struct {
    logic [1:0] a;
    logic [7:0] d;
  } bus_t;

  bus_t       exp_q[$];
  int         acc_q[$];
  int         acc_idx[$];
  logic       model_last = 1'b1;
  logic       cache_v = 1'b0;
  logic [8:0] cache_tag = '0;
  logic       prev_cs = 1'b1;
  int         width = 0;

  // Monitor: pushes expected bus phases on each accept, pops them at each pulse start.
  initial begin : mon
    logic w, hit;
    bus_t e;
    forever begin
      @(negedge clk);
      if (!ic_n) begin
        exp_q.delete();
        model_last = 1'b1;
        cache_v    = 1'b0;
        prev_cs    = 1'b1;
        width      = 0;
      end else begin
        if (|(req_valid & req_ready)) begin
          w = (req_valid == 2'b11) ? ~model_last : req_valid[1];
          check("ready_onehot", req_ready, w ? 32'd2 : 32'd1);
          hit = CACHE && cache_v && (cache_tag == {req_bank[w], req_addr[w]});
          if (!hit) begin
            e.a = {req_bank[w], 1'b0};
            e.d = req_addr[w];
            exp_q.push_back(e);
            cache_v   = 1'b1;
            cache_tag = {req_bank[w], req_addr[w]};
          end
          e.a = {req_bank[w], 1'b1};
          e.d = req_data[w];
          exp_q.push_back(e);
          model_last = w;
          acc_q.push_back(cyc);
          acc_idx.push_back(int'(w));
        end
        if (!cs_n && prev_cs) begin
          if (exp_q.size() == 0) begin
            check("unexpected_pulse", 1, 0);
          end else begin
            e = exp_q.pop_front();
            check("pulse_address", address, e.a);
            check("pulse_din", din, e.d);
          end
          check("pulse_wr_n", wr_n, 0);
          check("pulse_rd_n", rd_n, 1);
          check("pulse_last_grant", last_grant, model_last);
          width = 1;
        end else if (!cs_n) begin
          width++;
        end else if (!prev_cs) begin
          check("pulse_width", width, 2);
        end
        prev_cs = cs_n;
      end
    end
  end

  task automatic wait_accepts(input int n, input int maxc);
    for (int i = 0; i < maxc; i++) begin
      if (acc_q.size() >= n) break;
      @(negedge clk); #1;
    end
    if (acc_q.size() < n) check("accept_timeout", acc_q.size(), n);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 60; i++) begin
      @(negedge clk); #1;
      if (!busy) break;
    end
    if (busy) check("idle_timeout", busy, 0);
  endtask

  task automatic send(input int i, input logic b, input logic [7:0] a, input logic [7:0] d,
                      output int t_set);
    @(posedge clk); #1;
    t_set        = cyc;
    req_bank[i]  = b;
    req_addr[i]  = a;
    req_data[i]  = d;
    req_valid[i] = 1'b1;
    wait_accepts(acc_q.size() + 1, 60);
    @(posedge clk); #1;
    req_valid[i] = 1'b0;
    req_addr[i]  = 8'hEE;
    req_data[i]  = 8'hEE;
    req_bank[i]  = ~req_bank[i];
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : main
    int t_set, t0, t2, base, a0, dur;
    logic fr[16], fc[16];
    logic [1:0] fa[16];
    logic [7:0] fd[16];

    ic_n = 1'b0; req_valid = '0; req_bank = '0; req_addr = '0; req_data = '0;
    f_valid = '0; f_bank = '0; f_addr = '0; f_data = '0;
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    check("rst_cs_n", cs_n, 1);
    check("rst_wr_n", wr_n, 1);
    check("rst_rd_n", rd_n, 1);
    check("rst_address", address, 0);
    check("rst_din", din, 0);
    check("rst_busy", busy, 0);
    check("rst_last_grant", last_grant, 1);
    @(posedge clk); #1;
    ic_n = 1'b1;

    // Single write: exact strobe/busy timeline
    send(0, 1'b0, 8'hB0, 8'h31, t_set);
    t0 = acc_q[acc_q.size()-1];
    check("t1_ready_same_cycle", t0, t_set);
    for (int k = 1; k <= 13; k++) begin
      @(negedge clk); #1;
      check($sformatf("t1_busy_k%0d", cyc - t0), busy, (cyc - t0 <= 12) ? 1 : 0);
      check($sformatf("t1_cs_n_k%0d", cyc - t0), cs_n,
            (cyc - t0 == 1 || cyc - t0 == 2 || cyc - t0 == 7 || cyc - t0 == 8) ? 0 : 1);
      if (cyc - t0 == 1) begin
        check("t1_addr_phase_address", address, 0);
        check("t1_addr_phase_din", din, 8'hB0);
      end
      if (cyc - t0 == 7) begin
        check("t1_data_phase_address", address, 1);
        check("t1_data_phase_din", din, 8'h31);
      end
    end

    // Requester 1 on bank 1
    send(1, 1'b1, 8'h05, 8'h01, t_set);
    wait_idle();
    check("t2_last_grant", last_grant, 1);

    // Both valid continuously: strict alternation, 13-cycle period
    @(posedge clk); #1;
    base = acc_q.size();
    req_bank = 2'b10; req_addr[0] = 8'h10; req_data[0] = 8'hA0;
    req_addr[1] = 8'h20; req_data[1] = 8'hB1;
    req_valid = 2'b11;
    wait_accepts(base + 4, 80);
    @(posedge clk); #1;
    req_valid = 2'b00;
    wait_idle();
    if (acc_q.size() >= base + 4) begin
      for (int i = 0; i < 4; i++) check($sformatf("t3_grant_%0d", i), acc_idx[base+i], i % 2);
      for (int i = 1; i < 4; i++)
        check($sformatf("t3_period_%0d", i), acc_q[base+i] - acc_q[base+i-1], 13);
    end

    // Same {bank,addr} twice from requester 0
    @(posedge clk); #1;
    base = acc_q.size();
    req_bank[0] = 1'b0; req_addr[0] = 8'h40; req_data[0] = 8'h3F; req_valid[0] = 1'b1;
    wait_accepts(base + 1, 40);
    @(posedge clk); #1;
    req_data[0] = 8'h00;
    wait_accepts(base + 2, 40);
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    if (acc_q.size() >= base + 2) begin
      t2 = acc_q[base+1];
      check("t5_first_period", t2 - acc_q[base], 13);
      dur = 0;
      for (int i = 0; i < 40; i++) begin
        @(negedge clk); #1;
        if (!busy) begin
          dur = cyc - t2;
          break;
        end
      end
      check("t5_second_period", dur, CACHE ? 7 : 13);
    end

    // Reset in the middle of the data pulse
    send(0, 1'b0, 8'h55, 8'h66, t_set);
    t0 = acc_q[acc_q.size()-1];
    for (int i = 0; i < 20; i++) begin
      if (cyc >= t0 + 7) break;
      @(negedge clk); #1;
    end
    check("t4_in_data_pulse_cs_n", cs_n, 0);
    check("t4_in_data_pulse_address", address, 1);
    ic_n = 1'b0;
    #1;
    check("t4_async_cs_n", cs_n, 1);
    check("t4_async_wr_n", wr_n, 1);
    check("t4_async_busy", busy, 0);
    check("t4_async_address", address, 0);
    check("t4_async_din", din, 0);
    check("t4_async_last_grant", last_grant, 1);
    repeat (2) @(posedge clk);
    #1;
    ic_n = 1'b1;
    @(posedge clk); #1;
    base = acc_q.size();
    req_bank = 2'b10; req_addr[0] = 8'h55; req_data[0] = 8'h77;
    req_addr[1] = 8'h20; req_data[1] = 8'h88;
    req_valid = 2'b11;
    wait_accepts(base + 1, 20);
    @(posedge clk); #1;
    req_valid = 2'b00;
    if (acc_q.size() >= base + 1) check("t4_priority_after_reset", acc_idx[base], 0);
    @(negedge clk); #1;
    check("t4_restart_cs_n", cs_n, 0);
    check("t4_restart_addr_phase", address, 0);
    wait_idle();

    // Minimal timing instance: accept every 3 cycles, pulses back to back
    @(posedge clk); #1;
    f_addr[0] = 8'hA5; f_data[0] = 8'h5A; f_valid = 2'b01;
    for (int n = 0; n < 16; n++) begin
      @(negedge clk); #1;
      fr[n] = f_ready[0]; fc[n] = f_cs_n; fa[n] = f_address; fd[n] = f_din;
    end
    f_valid = 2'b00;
    a0 = -1;
    for (int n = 0; n < 16; n++) begin
      if (fr[n] && a0 < 0) a0 = n;
    end
    check("f_first_accept", a0, 0);
    if (a0 == 0) begin
      for (int j = 0; j < 3; j++) begin
        check($sformatf("f_ready_%0d", j), fr[3*j], 1);
        check($sformatf("f_idle_cs_%0d", j), fc[3*j], 1);
        check($sformatf("f_noready_%0d", j), fr[3*j+1], 0);
        check($sformatf("f_acs_%0d", j), fc[3*j+1], 0);
        check($sformatf("f_aaddr_%0d", j), fa[3*j+1], 0);
        check($sformatf("f_adin_%0d", j), fd[3*j+1], 8'hA5);
        check($sformatf("f_dcs_%0d", j), fc[3*j+2], 0);
        check($sformatf("f_daddr_%0d", j), fa[3*j+2], 1);
        check($sformatf("f_ddin_%0d", j), fd[3*j+2], 8'h5A);
      end
    end
    repeat (4) @(posedge clk);

    check("sb_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
